// File: rtl/countdown_pkg.sv
// Shared types and constants for the MM:SS countdown timer: state encoding,
// load limits, active-low seven-segment patterns and a divider-free BCD split.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [6:0] MAX_MIN = 7'd99;
    localparam logic [6:0] MAX_SEC = 7'd59;

    // {dp,g,f,e,d,c,b,a}, active-low; dp is off in every pattern
    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] BLANK = 8'hFF;

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return BLANK;
        endcase
    endfunction

    // Returns {tens, ones} for 0..99 using compares and a constant multiply only
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        tens = 4'd0;
        for (int i = 1; i < 10; i++) begin
            if (v >= 7'(i * 10)) tens = 4'(i);
        end
        return {tens, 4'(v - 7'(tens) * 7'd10)};
    endfunction

endpackage

// File: rtl/seg_mux_scan.sv
// Four-digit multiplexed seven-segment driver: scan divider, digit select and
// registered anode/cathode outputs, refreshed once per digit advance.
module seg_mux_scan
    import countdown_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    input  logic [3:0] m0,
    input  logic [3:0] m1,
    input  logic [3:0] dp_mask,
    input  logic       blank,
    output logic [7:0] an,
    output logic [7:0] dec_cat
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

    logic [SW-1:0] scan_cnt;
    logic [1:0]    digit_sel;
    logic          advance;
    logic [3:0]    bcd;
    logic [7:0]    an_next;
    logic [7:0]    cat_next;

    assign advance = (scan_cnt == SCAN_MAX);

    // digit_sel names the digit written at the next advance: S0, S1, M0, M1
    always_comb begin
        case (digit_sel)
            2'd0:    bcd = s0;
            2'd1:    bcd = s1;
            2'd2:    bcd = m0;
            default: bcd = m1;
        endcase
        cat_next = seg_of(bcd);
        if (dp_mask[digit_sel]) cat_next[7] = 1'b0;
        an_next = {4'hF, blank ? 4'hF : ~(4'b0001 << digit_sel)};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scan_cnt  <= '0;
            digit_sel <= 2'd0;
            an        <= 8'hFF;
            dec_cat   <= BLANK;
        end else if (advance) begin
            scan_cnt  <= '0;
            digit_sel <= digit_sel + 2'd1;
            an        <= an_next;
            dec_cat   <= cat_next;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown engine with pause/resume and a multiplexed display.
// Optional build macro COUNTDOWN_TIMER_BLINK_PAUSE_EN blinks the digits while paused.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int CLK_HZ  = 100000000,
    parameter int SCAN_HZ = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic [6:0] min,
    input  logic [6:0] sec,
    output logic       done,
    output logic [7:0] an,
    output logic [7:0] dec_cat
);

    localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CLK_HZ - 1);

    state_t            state, state_next;
    logic [6:0]        rem_min, rem_min_next;
    logic [6:0]        rem_sec, rem_sec_next;
    logic [TICK_W-1:0] tick_cnt, tick_next;
    logic              pause_q;
    logic [6:0]        clamp_min, clamp_sec;
    logic              wrap, terminal, resume;

    assign clamp_min = (min > MAX_MIN) ? MAX_MIN : min;
    assign clamp_sec = (sec > MAX_SEC) ? MAX_SEC : sec;
    assign wrap      = (tick_cnt == TICK_MAX);
    assign terminal  = wrap && (rem_min == 7'd0) && (rem_sec == 7'd1);
    assign resume    = (start && !pause) || (pause && !pause_q);
    assign done      = (state == DONE);

    // NOTE: every signal gets a default before the case so no path infers a latch
    always_comb begin
        state_next   = state;
        rem_min_next = rem_min;
        rem_sec_next = rem_sec;
        tick_next    = tick_cnt;
        if (stop) begin
            state_next   = IDLE;
            rem_min_next = 7'd0;
            rem_sec_next = 7'd0;
            tick_next    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (clamp_min != 7'd0 || clamp_sec != 7'd0)) begin
                        state_next   = RUN;
                        rem_min_next = clamp_min;
                        rem_sec_next = clamp_sec;
                        tick_next    = '0;
                    end
                end
                RUN: begin
                    // a terminal tick beats pause; an ordinary wrap does not
                    if (terminal) begin
                        state_next   = DONE;
                        rem_min_next = 7'd0;
                        rem_sec_next = 7'd0;
                        tick_next    = '0;
                    end else if (pause) begin
                        state_next = PAUSED;
                    end else if (wrap) begin
                        tick_next = '0;
                        if (rem_sec != 7'd0) begin
                            rem_sec_next = rem_sec - 7'd1;
                        end else begin
                            rem_sec_next = MAX_SEC;
                            rem_min_next = rem_min - 7'd1;
                        end
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
                PAUSED: begin
                    if (resume) state_next = RUN;
                end
                DONE: begin
                    if (start) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rem_min  <= 7'd0;
            rem_sec  <= 7'd0;
            tick_cnt <= '0;
            pause_q  <= 1'b0;
        end else begin
            state    <= state_next;
            rem_min  <= rem_min_next;
            rem_sec  <= rem_sec_next;
            tick_cnt <= tick_next;
            pause_q  <= pause;
        end
    end

    logic [6:0] disp_min, disp_sec;
    logic [7:0] min_bcd, sec_bcd;
    logic [3:0] dp_mask;
    logic       blank;

    assign disp_min = (state == IDLE) ? clamp_min : rem_min;
    assign disp_sec = (state == IDLE) ? clamp_sec : rem_sec;
    assign min_bcd  = to_bcd(disp_min);
    assign sec_bcd  = to_bcd(disp_sec);
    assign dp_mask  = (state == RUN || state == PAUSED) ? 4'b0100 : 4'b0000;

`ifdef COUNTDOWN_TIMER_BLINK_PAUSE_EN
    localparam int HALF   = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
    localparam int HALF_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [HALF_W-1:0] HALF_MAX = HALF_W'(HALF - 1);

    logic [HALF_W-1:0] half_cnt;
    logic              blink_off;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            half_cnt  <= '0;
            blink_off <= 1'b0;
        end else if (half_cnt == HALF_MAX) begin
            half_cnt  <= '0;
            blink_off <= !blink_off;
        end else begin
            half_cnt <= half_cnt + 1'b1;
        end
    end

    assign blank = (state == PAUSED) && blink_off;
`else
    assign blank = 1'b0;
`endif

    seg_mux_scan #(
        .SCAN_DIV(CLK_HZ / SCAN_HZ)
    ) u_scan (
        .clock  (clock),
        .reset  (reset),
        .s0     (sec_bcd[3:0]),
        .s1     (sec_bcd[7:4]),
        .m0     (min_bcd[3:0]),
        .m1     (min_bcd[7:4]),
        .dp_mask(dp_mask),
        .blank  (blank),
        .an     (an),
        .dec_cat(dec_cat)
    );

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer at CLK_HZ=20, SCAN_HZ=10: an IDLE display
// vector table plus hand-written sequences for timing, pause and priority cases.
module tb_countdown_timer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       pause = 1'b0;
    logic [6:0] min   = 7'd0;
    logic [6:0] sec   = 7'd0;
    logic       done;
    logic [7:0] an;
    logic [7:0] dec_cat;

    int n_checks = 0;
    int n_errors = 0;

    countdown_timer #(
        .CLK_HZ (20),
        .SCAN_HZ(10)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .stop   (stop),
        .pause  (pause),
        .min    (min),
        .sec    (sec),
        .done   (done),
        .an     (an),
        .dec_cat(dec_cat)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [6:0] min;
        logic [6:0] sec;
        int         m1, m0, s1, s0;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    function automatic logic [7:0] seg_exp(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Collect one pattern per digit as the scan visits them; ok=0 on a bad anode or timeout
    task automatic capture(output logic [31:0] pats, output logic ok);
        logic [7:0] p [4];
        bit         seen [4];
        bit         good;
        good = 1'b1;
        for (int k = 0; k < 4; k++) begin
            p[k]    = 8'h00;
            seen[k] = 1'b0;
        end
        for (int c = 0; c < 20; c++) begin
            step();
            case (an)
                8'hFE: begin p[0] = dec_cat; seen[0] = 1'b1; end
                8'hFD: begin p[1] = dec_cat; seen[1] = 1'b1; end
                8'hFB: begin p[2] = dec_cat; seen[2] = 1'b1; end
                8'hF7: begin p[3] = dec_cat; seen[3] = 1'b1; end
                default: good = 1'b0;
            endcase
            if (seen[0] && seen[1] && seen[2] && seen[3]) break;
        end
        pats = {p[3], p[2], p[1], p[0]};
        ok   = good && seen[0] && seen[1] && seen[2] && seen[3];
    endtask

    initial begin
        logic [31:0] pats;
        logic        ok;

        vecs[0] = '{min: 7'd0,   sec: 7'd0,  m1: 0, m0: 0, s1: 0, s0: 0};
        vecs[1] = '{min: 7'd5,   sec: 7'd9,  m1: 0, m0: 5, s1: 0, s0: 9};
        vecs[2] = '{min: 7'd12,  sec: 7'd34, m1: 1, m0: 2, s1: 3, s0: 4};
        vecs[3] = '{min: 7'd99,  sec: 7'd59, m1: 9, m0: 9, s1: 5, s0: 9};
        vecs[4] = '{min: 7'd120, sec: 7'd75, m1: 9, m0: 9, s1: 5, s0: 9};
        vecs[5] = '{min: 7'd100, sec: 7'd60, m1: 9, m0: 9, s1: 5, s0: 9};
        vecs[6] = '{min: 7'd45,  sec: 7'd7,  m1: 4, m0: 5, s1: 0, s0: 7};

        // Reset state
        repeat (3) step();
        check("reset_an", 32'(an), 32'hFF);
        check("reset_cat", 32'(dec_cat), 32'hFF);
        check("reset_done", 32'(done), 32'd0);
        reset = 1'b1;
        repeat (2) step();

        // IDLE shows clamped inputs live, no decimal point
        for (int i = 0; i < 7; i++) begin
            min = vecs[i].min;
            sec = vecs[i].sec;
            repeat (10) step();
            capture(pats, ok);
            check($sformatf("idle_scan_ok_%0d", i), 32'(ok), 32'd1);
            check($sformatf("idle_disp_%0d", i), pats,
                  {seg_exp(vecs[i].m1), seg_exp(vecs[i].m0),
                   seg_exp(vecs[i].s1), seg_exp(vecs[i].s0)});
        end

        // Start with 00:00 is ignored
        min = 7'd0; sec = 7'd0;
        pulse_start();
        repeat (25) step();
        check("zero_start_state", 32'(dut.state), 32'd0);
        check("zero_start_done", 32'(done), 32'd0);

        // 00:03 countdown to DONE
        min = 7'd0; sec = 7'd3;
        pulse_start();
        repeat (19) step();
        check("run3_c19", 32'({dut.rem_min, dut.rem_sec}), 32'({7'd0, 7'd3}));
        step();
        check("run3_c20", 32'({dut.rem_min, dut.rem_sec}), 32'({7'd0, 7'd2}));
        repeat (20) step();
        check("run3_c40", 32'({dut.rem_min, dut.rem_sec}), 32'({7'd0, 7'd1}));
        repeat (19) step();
        check("run3_done_c59", 32'(done), 32'd0);
        step();
        check("run3_c60", 32'({dut.rem_min, dut.rem_sec}), 32'({7'd0, 7'd0}));
        step();
        check("run3_done_c61", 32'(done), 32'd1);
        repeat (5) step();
        check("run3_done_held", 32'(done), 32'd1);
        pulse_stop();
        check("run3_stop_done", 32'(done), 32'd0);
        check("run3_stop_state", 32'(dut.state), 32'd0);

        // 02:00 borrows to 01:59; M0 carries the decimal point
        min = 7'd2; sec = 7'd0;
        pulse_start();
        repeat (20) step();
        check("run2m_c20", 32'({dut.rem_min, dut.rem_sec}), 32'({7'd1, 7'd59}));
        repeat (10) step();
        capture(pats, ok);
        check("run2m_scan_ok", 32'(ok), 32'd1);
        check("run2m_disp", pats, {8'hC0, 8'h79, 8'h92, 8'h90});
        pulse_stop();

        // Clamped load runs from 99:59
        min = 7'd120; sec = 7'd75;
        pulse_start();
        check("clamp_load", 32'({dut.rem_min, dut.rem_sec}), 32'({7'd99, 7'd59}));
        repeat (20) step();
        check("clamp_dec", 32'({dut.rem_min, dut.rem_sec}), 32'({7'd99, 7'd58}));
        pulse_stop();

        // Pause at tick 7, held 100 cycles, release, resume with start
        min = 7'd0; sec = 7'd5;
        pulse_start();
        repeat (7) step();
        check("pause_tick_before", 32'(dut.tick_cnt), 32'd7);
        pause = 1'b1;
        step();
        check("pause_state", 32'(dut.state), 32'd2);
        repeat (99) step();
        check("pause_rem_held", 32'({dut.rem_min, dut.rem_sec}), 32'({7'd0, 7'd5}));
        check("pause_tick_held", 32'(dut.tick_cnt), 32'd7);
        pause = 1'b0;
        repeat (10) step();
        check("pause_release_state", 32'(dut.state), 32'd2);
        pulse_start();
        check("resume_state", 32'(dut.state), 32'd1);
        repeat (12) step();
        check("resume_c12", 32'({dut.rem_min, dut.rem_sec}), 32'({7'd0, 7'd5}));
        step();
        check("resume_c13", 32'({dut.rem_min, dut.rem_sec}), 32'({7'd0, 7'd4}));

        // A rising edge of pause while PAUSED resumes
        pause = 1'b1;
        step();
        pause = 1'b0;
        step();
        check("edge_paused", 32'(dut.state), 32'd2);
        pause = 1'b1;
        step();
        check("edge_resume", 32'(dut.state), 32'd1);
        pause = 1'b0;
        pulse_stop();

        // stop beats start in the same cycle
        min = 7'd0; sec = 7'd5;
        pulse_start();
        repeat (3) step();
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        check("stop_start_state", 32'(dut.state), 32'd0);
        check("stop_start_rem", 32'({dut.rem_min, dut.rem_sec}), 32'd0);
        check("stop_start_tick", 32'(dut.tick_cnt), 32'd0);

        // Terminal tick beats pause; start in DONE returns to IDLE without loading
        min = 7'd0; sec = 7'd1;
        pulse_start();
        repeat (19) step();
        pause = 1'b1;
        step();
        pause = 1'b0;
        check("term_pause_state", 32'(dut.state), 32'd3);
        check("term_pause_done", 32'(done), 32'd1);
        pulse_start();
        check("done_start_state", 32'(dut.state), 32'd0);
        step();
        check("done_start_no_load", 32'(dut.state), 32'd0);
        check("done_start_rem", 32'({dut.rem_min, dut.rem_sec}), 32'd0);

        // Reset in the middle of RUN
        min = 7'd0; sec = 7'd5;
        pulse_start();
        repeat (10) step();
        reset = 1'b0;
        step();
        check("rst_run_state", 32'(dut.state), 32'd0);
        check("rst_run_done", 32'(done), 32'd0);
        check("rst_run_an", 32'(an), 32'hFF);
        check("rst_run_cat", 32'(dec_cat), 32'hFF);
        reset = 1'b1;
        repeat (30) step();
        check("rst_run_after_state", 32'(dut.state), 32'd0);
        check("rst_run_after_rem", 32'({dut.rem_min, dut.rem_sec}), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
